dmem_lsu: RTL and testbench

Load/store sequencer between the core's memory stage and the word-addressed data memory (11-bit word address, 32-bit data, combinational read, synchronous write). Accepts one RV32I byte-addressed load or store at a time, performs alignment, sign/zero extension and read-modify-write for sub-word stores, and flags misaligned, illegal or out-of-range accesses. All memory traffic is issued from registered state, so no core-side input reaches the memory port combinationally.

---
 rtl/dmem_lsu_pkg.sv | 11 +
 rtl/dmem_lsu_align.sv | 27 ++
 rtl/dmem_lsu.sv | 99 +++++++++
 tb/tb_dmem_lsu.sv | 125 ++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared funct3 codes, FSM states and memory geometry defaults
package dmem_lsu_pkg;
  localparam int MEM_WORDS = 1028;
  localparam int MEM_AW = 11;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, EXEC, WRITE, RESP} state_t;
endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  sh;
  always_comb begin
    sh = {off, 3'b000};
    b = rdata[sh +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    ldata = funct3 == F3_B  ? {{24{b[7]}}, b} :
            funct3 == F3_BU ? {24'b0, b} :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_HU ? {16'b0, h} : rdata;
    mdata = funct3 == F3_B ? (rdata & ~(32'hFF << sh)) | ({24'b0, wdata[7:0]} << sh) :
            funct3 == F3_H ? (off[1] ? {wdata[15:0], rdata[15:0]} : {rdata[31:16], wdata[15:0]}) :
            wdata;
  end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: one-at-a-time RV32I load/store sequencer with read-modify-write for sub-word stores
module dmem_lsu #(
  parameter int MEM_WORDS = dmem_lsu_pkg::MEM_WORDS,
  parameter int MEM_AW = dmem_lsu_pkg::MEM_AW
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_write,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);
  import dmem_lsu_pkg::*;
  state_t state, nxt;
  logic we_q;
  logic [2:0] f3_q;
  logic [MEM_AW+1:0] addr_q;
  logic [31:0] wdata_q, merged_q, ldata, mdata;
  logic acc, acc_err, sw;
  dmem_lsu_align u_align (
    .funct3(f3_q),
    .off(addr_q[1:0]),
    .rdata(i_mem_rdata),
    .wdata(wdata_q),
    .ldata(ldata),
    .mdata(mdata)
  );
  assign o_mem_addr = addr_q[MEM_AW+1:2];
  assign acc = i_req_valid && o_req_ready;
  assign sw = we_q && f3_q == F3_W;
  // Decode errors from the live request so a rejected access never leaves IDLE toward memory.
  always_comb begin
    acc_err = (i_req_we ? !(i_req_funct3 inside {F3_B, F3_H, F3_W})
                        : !(i_req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
           || (i_req_funct3[1:0] == 2'b01 && i_req_addr[0])
           || (i_req_funct3 == F3_W && i_req_addr[1:0] != 2'b00)
           || i_req_addr >= 32'(4 * MEM_WORDS);
  end
  always_comb begin
    nxt = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_mem_write = 1'b0;
    o_mem_wdata = '0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) nxt = acc_err ? RESP : EXEC;
      end
      EXEC: begin
        o_mem_write = sw;
        o_mem_wdata = sw ? wdata_q : '0;
        nxt = we_q && !sw ? WRITE : RESP;
      end
      WRITE: begin
        o_mem_write = 1'b1;
        o_mem_wdata = merged_q;
        nxt = RESP;
      end
      default: begin
        o_rsp_valid = 1'b1;
        nxt = IDLE;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      merged_q <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        we_q <= i_req_we;
        f3_q <= i_req_funct3;
        addr_q <= i_req_addr[MEM_AW+1:0];
        wdata_q <= i_req_wdata;
        o_rsp_rdata <= '0;
        o_rsp_err <= acc_err;
      end
      if (state == EXEC && !we_q) o_rsp_rdata <= ldata;
      if (state == EXEC) merged_q <= mdata;
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed checks of dmem_lsu against a behavioural word memory
module tb_dmem_lsu;
  logic clk = 1'b0, rstn = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_f3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, mem_write;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [10:0] mem_addr;
  logic [31:0] mem [0:2047];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] = mem_wdata;
  dmem_lsu dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_mem_write(mem_write), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  // Starts just after the accept edge; cycle n is sampled at the n-th following negedge.
  task automatic wait_rsp(input string tag, input int exp_cyc, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_wn, input int exp_wc, input logic [31:0] exp_wa, input logic [31:0] exp_wd);
    int got = 0, wn = 0, wc = 0, rdy = 0;
    logic [31:0] wa = '0, wd = '0;
    logic rdy_resp = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_write) begin wn++; wc = c; wa = 32'(mem_addr); wd = mem_wdata; end
      if (rsp_valid) begin got = c; rdy_resp = req_ready; break; end
      if (req_ready) rdy++;
    end
    chk({tag, " rsp_cycle"}, got, exp_cyc);
    chk({tag, " rdata"}, rsp_rdata, exp_rd);
    chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, " ready_busy"}, rdy, 0);
    chk({tag, " ready_resp"}, 32'(rdy_resp), 0);
    chk({tag, " writes"}, wn, exp_wn);
    if (exp_wn > 0) begin
      chk({tag, " wr_cycle"}, wc, exp_wc);
      chk({tag, " wr_addr"}, wa, exp_wa);
      chk({tag, " wr_data"}, wd, exp_wd);
    end
    @(negedge clk);
    chk({tag, " strobe_1cyc"}, 32'(rsp_valid), 0);
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h11223344;
    #12;
    chk("rst ready", 32'(req_ready), 1);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rdata", rsp_rdata, 0);
    chk("rst err", 32'(rsp_err), 0);
    chk("rst mem_write", 32'(mem_write), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_wdata", mem_wdata, 0);
    @(negedge clk) rstn = 1'b1;
    issue(1'b0, 3'b010, 32'h10, 0);
    wait_rsp("LW", 2, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    mem[4] = 32'h80FF1234;
    issue(1'b0, 3'b000, 32'h13, 0);
    wait_rsp("LB", 2, 32'hFFFFFF80, 0, 0, 0, 0, 0);
    issue(1'b0, 3'b100, 32'h13, 0);
    wait_rsp("LBU", 2, 32'h00000080, 0, 0, 0, 0, 0);
    issue(1'b0, 3'b001, 32'h12, 0);
    wait_rsp("LH", 2, 32'hFFFF80FF, 0, 0, 0, 0, 0);
    issue(1'b0, 3'b101, 32'h10, 0);
    wait_rsp("LHU", 2, 32'h00001234, 0, 0, 0, 0, 0);
    issue(1'b1, 3'b000, 32'h21, 32'hAB);
    wait_rsp("SB", 3, 0, 0, 1, 2, 8, 32'h1122AB44);
    chk("SB mem", mem[8], 32'h1122AB44);
    issue(1'b0, 3'b010, 32'h102, 0);
    wait_rsp("ERR LW mis", 1, 0, 1, 0, 0, 0, 0);
    issue(1'b1, 3'b001, 32'h5, 32'hFFFF);
    wait_rsp("ERR SH mis", 1, 0, 1, 0, 0, 0, 0);
    issue(1'b0, 3'b011, 32'h0, 0);
    wait_rsp("ERR f3", 1, 0, 1, 0, 0, 0, 0);
    issue(1'b1, 3'b010, 32'h1010, 32'h12345678);
    wait_rsp("ERR range", 1, 0, 1, 0, 0, 0, 0);
    issue(1'b0, 3'b010, 32'h100C, 0);
    wait_rsp("LW last", 2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = '0;
    wait_rsp("B2B SW", 2, 0, 0, 1, 1, 32'h10, 32'hCAFEF00D);
    chk("B2B ready_after", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp("B2B LW", 2, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    issue(1'b1, 3'b001, 32'h22, 32'h5555);
    @(posedge clk);
    #1 chk("RST in WRITE", 32'(mem_write), 1);
    rstn = 1'b0;
    #1 chk("RST write_drop", 32'(mem_write), 0);
    chk("RST rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk) rstn = 1'b1;
    chk("RST ready", 32'(req_ready), 1);
    repeat (2) begin
      @(negedge clk);
      chk("RST no_rsp", 32'(rsp_valid), 0);
    end
    issue(1'b0, 3'b010, 32'h20, 0);
    wait_rsp("RST mem", 2, 32'h1122AB44, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
